// File: rtl/ring_mem_responder.sv
// ring_mem_responder: ring-bus memory responder. Consumes Address/WriteData
// slots from the ring, stages write data in two 8-word ping-pong buffers,
// queues line commands for a DDR2 controller and returns read data on a
// separate return ring.
// Optional build macro: IREAD_PRIO_EN adds a 2-entry I-read FIFO that is
// served ahead of the main in-order command FIFO.
`timescale 1ns/1ps
module ring_mem_responder (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] RingIn,
  input  logic [3:0]  SlotTypeIn,
  input  logic [3:0]  SrcDestIn,
  output logic [31:0] RingOut,
  output logic [3:0]  SlotTypeOut,
  output logic [3:0]  SrcDestOut,
  output logic [31:0] RDreturn,
  output logic [3:0]  RDdest,
  output logic        memCmdValid,
  input  logic        memCmdReady,
  output logic        memCmdWrite,
  output logic [27:0] memCmdAddr,
  output logic [31:0] memWD,
  output logic        memWDvalid,
  input  logic        memWDready,
  input  logic [31:0] memRD,
  input  logic        memRDvalid,
  output logic        overflow
);

  localparam logic [3:0] SLOT_NULL  = 4'd7;
  localparam logic [3:0] SLOT_ADDR  = 4'd2;
  localparam logic [3:0] SLOT_WDATA = 4'd3;
  localparam int unsigned FIFO_DEPTH = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WDATA, RDATA} state_t;

  // tag = buffer id (bit 0) for writes, source core for reads
  typedef struct packed {
    logic        wr;
    logic [27:0] addr;
    logic [3:0]  tag;
  } cmd_t;

  state_t      state_q;
  cmd_t        cur_q;
  logic        from_i_q;
  logic [2:0]  beat_q;

  logic [31:0] buf_q [2][8];
  logic        fill_q;
  logic [3:0]  widx_q;
  logic [1:0]  busy_q;

  cmd_t        fifo_q [FIFO_DEPTH];
  logic [2:0]  wptr_q, rptr_q;
  logic [3:0]  cnt_q;

  logic is_addr, is_wd, wr_addr, dread, iread, rd_main;
  logic wd_ok, wr_ok, main_full, push, pop, pop_main, free_buf;
  logic sel_valid, sel_i, ovf_i, ovf_set;
  cmd_t push_cmd, sel_cmd;

  assign is_addr   = (SlotTypeIn == SLOT_ADDR);
  assign is_wd     = (SlotTypeIn == SLOT_WDATA);
  assign wr_addr   = is_addr && (RingIn[31:28] == 4'b0000);
  assign dread     = is_addr && (RingIn[31:28] == 4'b0001);
  assign iread     = is_addr && (RingIn[31:28] == 4'b0011);
  assign wd_ok     = is_wd && !busy_q[fill_q] && !widx_q[3];
  assign wr_ok     = wr_addr && !busy_q[fill_q];
  assign main_full = (cnt_q == 4'd8);
  assign push      = (wr_ok || rd_main) && !main_full;
  assign pop       = (state_q == ISSUE) && memCmdReady;
  assign pop_main  = pop && !from_i_q;
  assign free_buf  = (state_q == WDATA) && memWDready && (beat_q == 3'd7);

  // Command word built from the current Address slot
  always_comb begin
    push_cmd.wr   = wr_addr;
    push_cmd.addr = RingIn[27:0];
    push_cmd.tag  = wr_addr ? {3'b000, fill_q} : SrcDestIn;
  end

  assign ovf_set = (is_wd && (busy_q[fill_q] || widx_q[3]))
                || (wr_addr && (busy_q[fill_q] || !widx_q[3]))
                || ((wr_ok || rd_main) && main_full)
                || ovf_i;

`ifdef IREAD_PRIO_EN
  cmd_t       ififo_q [2];
  logic       iwptr_q, irptr_q;
  logic [1:0] icnt_q;
  logic       ipush, ipop;

  assign rd_main   = dread;
  assign ipush     = iread && (icnt_q != 2'd2);
  assign ovf_i     = iread && (icnt_q == 2'd2);
  assign ipop      = pop && from_i_q;
  assign sel_i     = (icnt_q != 2'd0);
  assign sel_cmd   = sel_i ? ififo_q[irptr_q] : fifo_q[rptr_q];
  assign sel_valid = sel_i || (cnt_q != 4'd0);

  // I-read FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iwptr_q <= 1'b0;
      irptr_q <= 1'b0;
      icnt_q  <= '0;
    end else begin
      if (ipush) iwptr_q <= ~iwptr_q;
      if (ipop)  irptr_q <= ~irptr_q;
      case ({ipush, ipop})
        2'b10:   icnt_q <= icnt_q + 2'd1;
        2'b01:   icnt_q <= icnt_q - 2'd1;
        default: icnt_q <= icnt_q;
      endcase
    end
  end

  // I-read FIFO storage
  always_ff @(posedge clock) begin
    if (ipush) ififo_q[iwptr_q] <= push_cmd;
  end
`else
  assign rd_main   = dread || iread;
  assign ovf_i     = 1'b0;
  assign sel_i     = 1'b0;
  assign sel_cmd   = fifo_q[rptr_q];
  assign sel_valid = (cnt_q != 4'd0);
`endif

  // Ring forwarding: consumed slots leave as Null, others pass after one cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      RingOut     <= '0;
      SlotTypeOut <= SLOT_NULL;
      SrcDestOut  <= '0;
    end else if (is_addr || is_wd) begin
      RingOut     <= '0;
      SlotTypeOut <= SLOT_NULL;
      SrcDestOut  <= '0;
    end else begin
      RingOut     <= RingIn;
      SlotTypeOut <= SlotTypeIn;
      SrcDestOut  <= SrcDestIn;
    end
  end

  // Ping-pong buffer bookkeeping; a buffer stays busy until its burst drains
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_q <= 1'b0;
      widx_q <= '0;
      busy_q <= '0;
      overflow <= 1'b0;
    end else begin
      if (free_buf) busy_q[cur_q.tag[0]] <= 1'b0;
      if (wd_ok)    widx_q <= widx_q + 4'd1;
      if (wr_addr)  widx_q <= '0;
      if (wr_ok && !main_full) begin
        busy_q[fill_q] <= 1'b1;
        fill_q         <= ~fill_q;
      end
      if (ovf_set) overflow <= 1'b1;
    end
  end

  // Write-data buffer storage
  always_ff @(posedge clock) begin
    if (wd_ok) buf_q[fill_q][widx_q[2:0]] <= RingIn;
  end

  // Main command FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push)     wptr_q <= wptr_q + 3'd1;
      if (pop_main) rptr_q <= rptr_q + 3'd1;
      case ({push, pop_main})
        2'b10:   cnt_q <= cnt_q + 4'd1;
        2'b01:   cnt_q <= cnt_q - 4'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Main command FIFO storage
  always_ff @(posedge clock) begin
    if (push) fifo_q[wptr_q] <= push_cmd;
  end

  // Command/data sequencer; the head entry is latched on leaving IDLE and
  // popped only at the command handshake
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      from_i_q    <= 1'b0;
      beat_q      <= '0;
      memCmdValid <= 1'b0;
      memCmdWrite <= 1'b0;
      memCmdAddr  <= '0;
      memWD       <= '0;
      memWDvalid  <= 1'b0;
      RDreturn    <= '0;
      RDdest      <= '0;
    end else begin
      RDreturn <= '0;
      RDdest   <= '0;
      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            cur_q       <= sel_cmd;
            from_i_q    <= sel_i;
            memCmdValid <= 1'b1;
            memCmdWrite <= sel_cmd.wr;
            memCmdAddr  <= sel_cmd.addr;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (memCmdReady) begin
            memCmdValid <= 1'b0;
            beat_q      <= '0;
            if (cur_q.wr) begin
              memWDvalid <= 1'b1;
              memWD      <= buf_q[cur_q.tag[0]][0];
              state_q    <= WDATA;
            end else begin
              state_q <= RDATA;
            end
          end
        end
        WDATA: begin
          if (memWDready) begin
            if (beat_q == 3'd7) begin
              memWDvalid <= 1'b0;
              memWD      <= '0;
              state_q    <= IDLE;
            end else begin
              beat_q <= beat_q + 3'd1;
              memWD  <= buf_q[cur_q.tag[0]][beat_q + 3'd1];
            end
          end
        end
        RDATA: begin
          if (memRDvalid) begin
            RDreturn <= memRD;
            RDdest   <= cur_q.tag;
            if (beat_q == 3'd7) state_q <= IDLE;
            else                beat_q  <= beat_q + 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_mem_responder.sv
// tb_ring_mem_responder: directed self-checking bench for ring_mem_responder.
// Expectations for the IREAD_PRIO_EN build are selected by the same macro.
`timescale 1ns/1ps
module tb_ring_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] RingIn;
  logic [3:0]  SlotTypeIn, SrcDestIn;
  logic [31:0] RingOut;
  logic [3:0]  SlotTypeOut, SrcDestOut;
  logic [31:0] RDreturn;
  logic [3:0]  RDdest;
  logic        memCmdValid, memCmdReady, memCmdWrite;
  logic [27:0] memCmdAddr;
  logic [31:0] memWD;
  logic        memWDvalid, memWDready;
  logic [31:0] memRD;
  logic        memRDvalid;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  ring_mem_responder dut (
    .clock(clock), .reset(reset),
    .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SrcDestIn(SrcDestIn),
    .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SrcDestOut(SrcDestOut),
    .RDreturn(RDreturn), .RDdest(RDdest),
    .memCmdValid(memCmdValid), .memCmdReady(memCmdReady),
    .memCmdWrite(memCmdWrite), .memCmdAddr(memCmdAddr),
    .memWD(memWD), .memWDvalid(memWDvalid), .memWDready(memWDready),
    .memRD(memRD), .memRDvalid(memRDvalid),
    .overflow(overflow)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic slot(input logic [3:0] t, input logic [31:0] d, input logic [3:0] s);
    SlotTypeIn = t; RingIn = d; SrcDestIn = s;
    step();
    SlotTypeIn = 4'd7; RingIn = '0; SrcDestIn = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic wait_cmd(input logic exp_wr, input logic [27:0] exp_addr);
    int n = 0;
    while (!memCmdValid && n < 20) begin step(); n++; end
    checks++;
    if (memCmdValid !== 1'b1) begin errors++; $display("FAIL cmd_valid addr=%h got %b want 1", exp_addr, memCmdValid); end
    checks++;
    if (memCmdWrite !== exp_wr) begin errors++; $display("FAIL cmd_write addr=%h got %b want %b", exp_addr, memCmdWrite, exp_wr); end
    checks++;
    if (memCmdAddr !== exp_addr) begin errors++; $display("FAIL cmd_addr got %h want %h", memCmdAddr, exp_addr); end
  endtask

  task automatic serve_read(input logic [3:0] src, input logic [31:0] base);
    memCmdReady = 1'b1;
    step();
    memCmdReady = 1'b0;
    for (int j = 0; j < 8; j++) begin
      memRD = base + 32'(j); memRDvalid = 1'b1;
      step();
      checks++;
      if (RDdest !== src) begin errors++; $display("FAIL rd_dest beat %0d got %0d want %0d", j, RDdest, src); end
      checks++;
      if (RDreturn !== base + 32'(j)) begin errors++; $display("FAIL rd_data beat %0d got %h want %h", j, RDreturn, base + 32'(j)); end
    end
    memRDvalid = 1'b0; memRD = '0;
    step();
    checks++;
    if ({RDdest, RDreturn} !== 36'd0) begin errors++; $display("FAIL rd_idle got dest=%0d data=%h want 0/0", RDdest, RDreturn); end
  endtask

  task automatic stream_write(input logic [31:0] base);
    int n = 0;
    while (!memWDvalid && n < 20) begin step(); n++; end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (memWDvalid !== 1'b1 || memWD !== base + 32'(i)) begin
        errors++; $display("FAIL wd_beat %0d got v=%b d=%h want v=1 d=%h", i, memWDvalid, memWD, base + 32'(i));
      end
      step();
    end
    checks++;
    if (memWDvalid !== 1'b0) begin errors++; $display("FAIL wd_end got %b want 0", memWDvalid); end
  endtask

  task automatic serve_write(input logic [31:0] base);
    memCmdReady = 1'b1;
    step();
    memCmdReady = 1'b0;
    memWDready = 1'b1;
    stream_write(base);
    memWDready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    checks++;
    if (SlotTypeOut !== 4'd7) begin errors++; $display("FAIL rst_slottype got %h want 7", SlotTypeOut); end
    checks++;
    if ({RingOut, SrcDestOut, RDreturn, RDdest, memCmdValid, memCmdWrite, memCmdAddr, memWD, memWDvalid, overflow} !== '0) begin
      errors++; $display("FAIL rst_outputs got nonzero RingOut=%h RDdest=%h cmdv=%b wdv=%b ovf=%b want all 0", RingOut, RDdest, memCmdValid, memWDvalid, overflow);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_token();
    SlotTypeIn = 4'd1; RingIn = 32'h3; SrcDestIn = 4'd2;
    #1;
    checks++;
    if (SlotTypeOut !== 4'd7) begin errors++; $display("FAIL token_early got %h want 7", SlotTypeOut); end
    step();
    SlotTypeIn = 4'd7; RingIn = '0; SrcDestIn = '0;
    checks++;
    if ({RingOut, SlotTypeOut, SrcDestOut} !== {32'h3, 4'd1, 4'd2}) begin
      errors++; $display("FAIL token_fwd got %h/%h/%h want 00000003/1/2", RingOut, SlotTypeOut, SrcDestOut);
    end
    slot(4'd7, 32'h55, 4'd1);
    checks++;
    if ({RingOut, SlotTypeOut, SrcDestOut} !== {32'h55, 4'd7, 4'd1}) begin
      errors++; $display("FAIL null_fwd got %h/%h/%h want 00000055/7/1", RingOut, SlotTypeOut, SrcDestOut);
    end
  endtask

  task automatic test_dread();
    memCmdReady = 1'b0;
    slot(4'd2, {4'h1, 28'h0000040}, 4'd3);
    checks++;
    if ({RingOut, SlotTypeOut, SrcDestOut} !== {32'h0, 4'd7, 4'd0}) begin
      errors++; $display("FAIL addr_null got %h/%h/%h want 0/7/0", RingOut, SlotTypeOut, SrcDestOut);
    end
    wait_cmd(1'b0, 28'h0000040);
    serve_read(4'd3, 32'hA0);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL dread_ovf got %b want 0", overflow); end
  endtask

  task automatic test_write();
    for (int i = 0; i < 8; i++) begin
      slot(4'd3, 32'h10 + 32'(i), 4'd5);
      if (i == 0) begin
        checks++;
        if ({RingOut, SlotTypeOut, SrcDestOut} !== {32'h0, 4'd7, 4'd0}) begin
          errors++; $display("FAIL wd_null got %h/%h/%h want 0/7/0", RingOut, SlotTypeOut, SrcDestOut);
        end
      end
    end
    slot(4'd2, {4'h0, 28'h0000080}, 4'd5);
    wait_cmd(1'b1, 28'h0000080);
    serve_write(32'h10);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL write_ovf got %b want 0", overflow); end
  endtask

  task automatic test_fifo_full();
    logic seen;
    memCmdReady = 1'b0;
    for (int i = 0; i < 9; i++) begin
      slot(4'd2, {4'h1, 28'h100 + 28'(i)}, 4'(i + 1));
      if (i == 7) begin
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL fifo_8th_ovf got %b want 0", overflow); end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL fifo_9th_ovf got %b want 1", overflow); end
    for (int k = 0; k < 8; k++) begin
      wait_cmd(1'b0, 28'h100 + 28'(k));
      serve_read(4'(k + 1), 32'hB00 + 32'(16 * k));
    end
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (memCmdValid) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL fifo_9th_dropped got cmd want none"); end
  endtask

  task automatic test_short_write();
    do_reset();
    for (int i = 0; i < 3; i++) slot(4'd3, 32'h77, 4'd7);
    slot(4'd2, {4'h0, 28'h0000500}, 4'd7);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL short_write_ovf got %b want 1", overflow); end
    wait_cmd(1'b1, 28'h0000500);
  endtask

  task automatic test_back_to_back();
    logic seen;
    do_reset();
    memCmdReady = 1'b1;
    memWDready = 1'b0;
    for (int i = 0; i < 8; i++) slot(4'd3, 32'h20 + 32'(i), 4'd5);
    slot(4'd2, {4'h0, 28'h0000200}, 4'd5);
    for (int i = 0; i < 8; i++) slot(4'd3, 32'h30 + 32'(i), 4'd5);
    slot(4'd2, {4'h0, 28'h0000210}, 4'd5);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_two_ovf got %b want 0", overflow); end
    checks++;
    if (memWDvalid !== 1'b1 || memWD !== 32'h20) begin
      errors++; $display("FAIL b2b_stall got v=%b d=%h want v=1 d=00000020", memWDvalid, memWD);
    end
    slot(4'd3, 32'h40, 4'd5);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_third_ovf got %b want 1", overflow); end
    for (int i = 1; i < 8; i++) slot(4'd3, 32'h40 + 32'(i), 4'd5);
    slot(4'd2, {4'h0, 28'h0000220}, 4'd5);
    memWDready = 1'b1;
    stream_write(32'h20);
    wait_cmd(1'b1, 28'h0000210);
    stream_write(32'h30);
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (memCmdValid || memWDvalid) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL b2b_third_dropped got activity want none"); end
    memCmdReady = 1'b0;
    memWDready = 1'b0;
  endtask

  task automatic test_prio();
    do_reset();
    memCmdReady = 1'b0;
    slot(4'd2, {4'h1, 28'h0000300}, 4'd1);
    slot(4'd2, {4'h1, 28'h0000310}, 4'd2);
    slot(4'd2, {4'h3, 28'h0000320}, 4'd4);
    wait_cmd(1'b0, 28'h0000300);
    serve_read(4'd1, 32'hC0);
`ifdef IREAD_PRIO_EN
    wait_cmd(1'b0, 28'h0000320);
    serve_read(4'd4, 32'hD0);
    wait_cmd(1'b0, 28'h0000310);
    serve_read(4'd2, 32'hE0);
`else
    wait_cmd(1'b0, 28'h0000310);
    serve_read(4'd2, 32'hE0);
    wait_cmd(1'b0, 28'h0000320);
    serve_read(4'd4, 32'hD0);
`endif
  endtask

  task automatic test_reset_midburst();
    logic seen;
    memCmdReady = 1'b0;
    slot(4'd2, {4'h1, 28'h0000400}, 4'd6);
    wait_cmd(1'b0, 28'h0000400);
    memCmdReady = 1'b1;
    step();
    memCmdReady = 1'b0;
    for (int j = 0; j < 3; j++) begin
      memRD = 32'hF0 + 32'(j); memRDvalid = 1'b1;
      step();
    end
    checks++;
    if (RDdest !== 4'd6) begin errors++; $display("FAIL mid_pre_dest got %0d want 6", RDdest); end
    reset = 1'b0;
    #1;
    checks++;
    if ({RDdest, RDreturn, memCmdValid, SlotTypeOut} !== {4'd0, 32'd0, 1'b0, 4'd7}) begin
      errors++; $display("FAIL mid_async_rst got dest=%0d data=%h cmdv=%b st=%h want 0/0/0/7", RDdest, RDreturn, memCmdValid, SlotTypeOut);
    end
    step();
    reset = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      if (RDdest !== 4'd0 || memWDvalid !== 1'b0) seen = 1'b1;
    end
    memRDvalid = 1'b0; memRD = '0;
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL mid_abandon got beats after reset want none"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    RingIn = '0; SlotTypeIn = 4'd7; SrcDestIn = '0;
    memCmdReady = 1'b0; memWDready = 1'b0;
    memRD = '0; memRDvalid = 1'b0;
    test_reset();
    test_token();
    test_dread();
    test_write();
    test_fifo_full();
    test_short_write();
    test_back_to_back();
    test_prio();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
